cluster_tracker: RTL and testbench

- Parametrised successor to the fixed three-colour cluster block.
- Streams raster-ordered 12-bit RGB pixels and matches each pixel against NUM_COLORS runtime-programmable reference colours within a per-channel tolerance.
- Accumulates per-colour pixel count and coordinate sums; at frame end a shared sequential divider computes floor centroids and flags colours with too few hits.
- Sits between the pixel pipeline and the marker/pose logic; its results feed downstream tracking once per frame.

---
 rtl/cluster_tracker.sv | 211 +++++++++++++++++++++
 tb/tb_cluster_tracker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_tracker.sv
`default_nettype none
// ============================================================================
// Module  : cluster_tracker
// Purpose : Per-frame colour blob tracker. It matches pixels against
//           programmable reference colours and accumulates count and
//           coordinate sums, then computes floor centroids with one shared
//           restoring divider.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module cluster_tracker #(
  parameter int  IMG_WIDTH  = 640,
  parameter int  IMG_HEIGHT = 480,
  parameter int  NUM_COLORS = 4,
  parameter int  TOL        = 16,
  parameter int  MIN_COUNT  = 8,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT),
  localparam int IW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
  localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1),
  localparam int SW = ((XW > YW) ? XW : YW) + CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [IW-1:0]            cfg_idx,
  input  logic [11:0]              cfg_r,
  input  logic [11:0]              cfg_g,
  input  logic [11:0]              cfg_b,
  input  logic [11:0]              pixel_r,
  input  logic [11:0]              pixel_g,
  input  logic [11:0]              pixel_b,
  input  logic                     pixel_valid,
  input  logic [XW-1:0]            x,
  input  logic [YW-1:0]            y,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_COLORS-1:0]    found,
  output logic [NUM_COLORS*XW-1:0] centroid_x,
  output logic [NUM_COLORS*YW-1:0] centroid_y,
  output logic [NUM_COLORS*CW-1:0] pix_count
);

  localparam int JW = $clog2(2 * NUM_COLORS);
  localparam int BW = $clog2(SW);
  localparam logic [JW-1:0] JOB_LAST = JW'(2 * NUM_COLORS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);
  localparam logic signed [12:0] TOL_P = 13'(TOL);
  localparam logic signed [12:0] TOL_N = 13'(-TOL);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_COUNT);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]                      state_q;
  logic [NUM_COLORS-1:0][11:0]     ref_r_q, ref_g_q, ref_b_q;
  logic [NUM_COLORS-1:0][CW-1:0]   count_q;
  logic [NUM_COLORS-1:0][SW-1:0]   sumx_q, sumy_q;
  logic [NUM_COLORS-1:0][XW-1:0]   cx_stage_q;
  logic [NUM_COLORS-1:0][YW-1:0]   cy_stage_q;
  logic [JW-1:0]                   job_q;
  logic [BW-1:0]                   bit_q;
  logic [CW-1:0]                   rem_q, rem_d, rem_base_w;
  logic [SW-1:0]                   quo_q, quo_d;
  logic                            done_q;
  logic [NUM_COLORS-1:0]           found_q;
  logic [NUM_COLORS*XW-1:0]        centroid_x_q;
  logic [NUM_COLORS*YW-1:0]        centroid_y_q;
  logic [NUM_COLORS*CW-1:0]        pix_count_q;

  logic [NUM_COLORS-1:0]           win_w;
  logic                            taken_w;
  logic                            frame_end_w;
  logic [SW-1:0]                   dividend_w;
  logic [CW-1:0]                   divisor_w;
  logic [CW:0]                     trial_w, diff_w;
  logic                            qbit_w;
  logic                            valid_w;

  function automatic logic near(input logic [11:0] p, input logic [11:0] r);
    logic signed [12:0] d;
    d = $signed({p[11], p}) - $signed({r[11], r});
    return (d <= TOL_P) && (d >= TOL_N);
  endfunction

  // Lowest-index match wins, so at most one accumulator moves per pixel.
  always_comb begin
    win_w   = '0;
    taken_w = 1'b0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (!taken_w && near(pixel_r, ref_r_q[i]) && near(pixel_g, ref_g_q[i])
          && near(pixel_b, ref_b_q[i])) begin
        win_w[i] = 1'b1;
        taken_w  = 1'b1;
      end
    end
  end

  assign frame_end_w = pixel_valid && (x == XW'(IMG_WIDTH - 1)) && (y == YW'(IMG_HEIGHT - 1));

  // Job 2i divides colour i's x sum, job 2i+1 its y sum; one quotient bit per cycle.
  always_comb begin
    dividend_w = '0;
    divisor_w  = '0;
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (job_q == JW'(2 * i)) begin
        dividend_w = sumx_q[i];
        divisor_w  = count_q[i];
      end
      if (job_q == JW'(2 * i + 1)) begin
        dividend_w = sumy_q[i];
        divisor_w  = count_q[i];
      end
    end
    rem_base_w = (bit_q == '0) ? '0 : rem_q;
    trial_w    = {rem_base_w, dividend_w[BIT_LAST - bit_q]};
    diff_w     = trial_w - {1'b0, divisor_w};
    qbit_w     = (trial_w >= {1'b0, divisor_w});
    rem_d      = qbit_w ? diff_w[CW-1:0] : trial_w[CW-1:0];
    quo_d      = {quo_q[SW-2:0], qbit_w};
    valid_w    = (divisor_w >= MIN_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_ACCUM;
      ref_r_q      <= '0;
      ref_g_q      <= '0;
      ref_b_q      <= '0;
      count_q      <= '0;
      sumx_q       <= '0;
      sumy_q       <= '0;
      cx_stage_q   <= '0;
      cy_stage_q   <= '0;
      job_q        <= '0;
      bit_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      done_q       <= 1'b0;
      found_q      <= '0;
      centroid_x_q <= '0;
      centroid_y_q <= '0;
      pix_count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (cfg_we && (int'(cfg_idx) < NUM_COLORS)) begin
        ref_r_q[cfg_idx] <= cfg_r;
        ref_g_q[cfg_idx] <= cfg_g;
        ref_b_q[cfg_idx] <= cfg_b;
      end
      case (state_q)
        S_ACCUM: begin
          if (pixel_valid) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
              if (win_w[i]) begin
                count_q[i] <= count_q[i] + CW'(1);
                sumx_q[i]  <= sumx_q[i] + SW'(x);
                sumy_q[i]  <= sumy_q[i] + SW'(y);
              end
            end
            if (frame_end_w) begin
              state_q <= S_DIV;
              job_q   <= '0;
              bit_q   <= '0;
            end
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (bit_q == BIT_LAST) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
              if (job_q == JW'(2 * i))
                cx_stage_q[i] <= valid_w ? quo_d[XW-1:0] : '0;
              if (job_q == JW'(2 * i + 1))
                cy_stage_q[i] <= valid_w ? quo_d[YW-1:0] : '0;
            end
            bit_q <= '0;
            if (job_q == JOB_LAST) state_q <= S_OUT;
            else                   job_q   <= job_q + JW'(1);
          end else begin
            bit_q <= bit_q + BW'(1);
          end
        end
        S_OUT: begin
          for (int i = 0; i < NUM_COLORS; i++) begin
            found_q[i]                <= (count_q[i] >= MIN_C);
            centroid_x_q[i*XW +: XW]  <= cx_stage_q[i];
            centroid_y_q[i*YW +: YW]  <= cy_stage_q[i];
            pix_count_q[i*CW +: CW]   <= count_q[i];
          end
          count_q <= '0;
          sumx_q  <= '0;
          sumy_q  <= '0;
          done_q  <= 1'b1;
          state_q <= S_ACCUM;
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

  assign busy       = (state_q != S_ACCUM);
  assign done       = done_q;
  assign found      = found_q;
  assign centroid_x = centroid_x_q;
  assign centroid_y = centroid_y_q;
  assign pix_count  = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cluster_tracker.sv
`default_nettype none
// ============================================================================
// Module  : tb_cluster_tracker
// Purpose : Directed frame-level bench for cluster_tracker (default sizes).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cluster_tracker;

  localparam int NC = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 19;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [11:0]   cfg_r, cfg_g, cfg_b;
  logic [11:0]   pixel_r, pixel_g, pixel_b;
  logic          pixel_valid;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          busy, done;
  logic [NC-1:0] found;
  logic [NC*XW-1:0] centroid_x;
  logic [NC*YW-1:0] centroid_y;
  logic [NC*CW-1:0] pix_count;

  cluster_tracker dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_valid(pixel_valid), .x(x), .y(y),
    .busy(busy), .done(done), .found(found),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .pix_count(pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 no blob, 1 4x4 block at (bx,by), 2 five-pixel run starting at (bx,by)
  // noise: 0 clean, 1 +/-5 on every blob, 2 exactly +/-17 on blob 0 only
  typedef struct packed {
    logic [2:0][1:0]     kind;
    logic [2:0][9:0]     bx;
    logic [2:0][8:0]     by;
    logic [1:0]          noise;
    logic [3:0]          found;
    logic [3:0][9:0]     cx;
    logic [3:0][8:0]     cy;
    logic [3:0][18:0]    cnt;
  } vec_t;

  vec_t vecs [5];
  int   ref_r [4];
  int   ref_g [4];
  int   ref_b [4];
  int   n_vec;
  int   n_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ref(input int idx, input int r, input int g, input int b);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_r   = 12'(r);
    cfg_g   = 12'(g);
    cfg_b   = 12'(b);
    ref_r[idx] = r;
    ref_g[idx] = g;
    ref_b[idx] = b;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pix(input int r, input int g, input int b, input int px, input int py);
    pixel_valid = 1'b1;
    pixel_r = 12'(r);
    pixel_g = 12'(g);
    pixel_b = 12'(b);
    x = XW'(px);
    y = YW'(py);
    tick();
    pixel_valid = 1'b0;
  endtask

  function automatic int nz(input int mode, input int blob);
    if (mode == 1) return int'($urandom_range(0, 10)) - 5;
    if (mode == 2 && blob == 0) return ($urandom_range(0, 1) == 0) ? 17 : -17;
    return 0;
  endfunction

  task automatic blob_pix(input int i, input int mode, input int px, input int py);
    pix(ref_r[i] + nz(mode, i), ref_g[i] + nz(mode, i), ref_b[i] + nz(mode, i), px, py);
  endtask

  task automatic apply_frame(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      if (v.kind[i] == 2'd1) begin
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            blob_pix(i, int'(v.noise), int'(v.bx[i]) + dx, int'(v.by[i]) + dy);
      end else if (v.kind[i] == 2'd2) begin
        for (int dx = 0; dx < 5; dx++)
          blob_pix(i, int'(v.noise), int'(v.bx[i]) + dx, int'(v.by[i]));
      end
    end
    pix(300, 300, 300, 639, 479);
  endtask

  // Counts edges after the frame-end edge until done; optionally pushes
  // colour-1 pixels (and a fake frame end) while the block is busy.
  task automatic wait_done(input bit stuff, output int cyc, output bit seen, output bit busy_ok);
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    while (cyc < 400) begin
      if (stuff) begin
        pixel_valid = 1'b1;
        pixel_r = 12'(ref_r[1]); pixel_g = 12'(ref_g[1]); pixel_b = 12'(ref_b[1]);
        x = (cyc == 100) ? XW'(639) : XW'(cyc % 600);
        y = (cyc == 100) ? YW'(479) : YW'(50);
      end
      tick();
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit stuff);
    int cyc;
    bit seen, bok;
    apply_frame(v);
    wait_done(stuff, cyc, seen, bok);
    chk({tag, " done seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'd233);
    chk({tag, " busy held"}, 64'(bok), 64'd1);
    chk({tag, " found"}, 64'(found), 64'(v.found));
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("%s cx%0d", tag, i), 64'(centroid_x[i*XW +: XW]), 64'(v.cx[i]));
      chk($sformatf("%s cy%0d", tag, i), 64'(centroid_y[i*YW +: YW]), 64'(v.cy[i]));
      chk($sformatf("%s cnt%0d", tag, i), 64'(pix_count[i*CW +: CW]), 64'(v.cnt[i]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " found"}, 64'(found), 64'd0);
    chk({tag, " centroid_x"}, 64'(centroid_x), 64'd0);
    chk({tag, " centroid_y"}, 64'(centroid_y), 64'd0);
    chk({tag, " pix_count"}, 64'(pix_count), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
  endtask

  task automatic no_done_for(input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk({tag, " no done"}, 64'(seen), 64'd0);
  endtask

  task automatic scen1_refs();
    set_ref(0, 50, 100, 150);
    set_ref(1, 450, 500, 550);
    set_ref(2, 900, 950, 1000);
    set_ref(3, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      ref_r[i] = 0; ref_g[i] = 0; ref_b[i] = 0;
    end

    // Scenario 1 and its noisy variants, plus a 5-pixel colour-1 run.
    vecs[0] = '0;
    vecs[0].kind  = {2'd1, 2'd1, 2'd1};
    vecs[0].bx[0] = 10'd158; vecs[0].by[0] = 9'd118;
    vecs[0].bx[1] = 10'd478; vecs[0].by[1] = 9'd118;
    vecs[0].bx[2] = 10'd318; vecs[0].by[2] = 9'd358;
    vecs[0].found = 4'b0111;
    vecs[0].cx[0] = 10'd159; vecs[0].cy[0] = 9'd119; vecs[0].cnt[0] = 19'd16;
    vecs[0].cx[1] = 10'd479; vecs[0].cy[1] = 9'd119; vecs[0].cnt[1] = 19'd16;
    vecs[0].cx[2] = 10'd319; vecs[0].cy[2] = 9'd359; vecs[0].cnt[2] = 19'd16;

    vecs[1] = vecs[0];
    vecs[1].noise = 2'd1;

    vecs[2] = vecs[0];
    vecs[2].noise  = 2'd2;
    vecs[2].found  = 4'b0110;
    vecs[2].cx[0]  = 10'd0; vecs[2].cy[0] = 9'd0; vecs[2].cnt[0] = 19'd0;

    vecs[3] = vecs[0];
    vecs[3].kind[1] = 2'd2;
    vecs[3].bx[1]   = 10'd600; vecs[3].by[1] = 9'd10;
    vecs[3].found   = 4'b0101;
    vecs[3].cx[1]   = 10'd0; vecs[3].cy[1] = 9'd0; vecs[3].cnt[1] = 19'd5;

    vecs[4] = vecs[0];
    vecs[4].bx[2] = 10'd100; vecs[4].by[2] = 9'd400;
    vecs[4].cx[2] = 10'd101; vecs[4].cy[2] = 9'd401;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_r = '0; cfg_g = '0; cfg_b = '0;
    pixel_r = '0; pixel_g = '0; pixel_b = '0;
    pixel_valid = 1'b0; x = '0; y = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_zero("reset");

    scen1_refs();
    for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k), 1'b0);

    // Duplicate reference: lower index must take every match.
    set_ref(3, 50, 100, 150);
    run_vec(vecs[0], "dupref", 1'b0);
    set_ref(3, 0, 0, 0);

    // Pixels and a fake frame end pushed while busy must be dropped.
    run_vec(vecs[0], "stuffed", 1'b1);
    run_vec(vecs[0], "after_stuff", 1'b0);

    // Reference rewrite between frames, negative colour values.
    set_ref(2, -700, -800, -900);
    run_vec(vecs[4], "newref2", 1'b0);

    // Mid-frame reset at y=200: outputs clear, no done, pixels forgotten.
    scen1_refs();
    for (int dx = 0; dx < 4; dx++) blob_pix(0, 0, 10 + dx, 200);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_zero("rst_frame");
    no_done_for(300, "rst_frame");
    scen1_refs();
    run_vec(vecs[0], "post_rst_frame", 1'b0);

    // Mid-divide reset.
    apply_frame(vecs[0]);
    for (int k = 0; k < 50; k++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_zero("rst_div");
    no_done_for(300, "rst_div");
    scen1_refs();
    run_vec(vecs[0], "post_rst_div", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
